pu_shared_atomic_mem: RTL and testbench



---
 rtl/pu_shared_atomic_mem_pkg.sv | 42 ++++
 rtl/pu_amo_bank.sv | 141 ++++++++++++++
 rtl/ram_1r1w.sv | 26 ++
 rtl/rr_arb.sv | 33 +++
 rtl/pu_shared_atomic_mem.sv | 107 ++++++++++
 tb/tb_pu_shared_atomic_mem.sv | 244 ++++++++++++++++++++++++
 6 files changed

// File: rtl/pu_shared_atomic_mem_pkg.sv
// pu_shared_atomic_mem_pkg: opcodes and shared sizing helpers for the banked atomic memory
package pu_shared_atomic_mem_pkg;

  typedef enum logic [3:0] {
    OP_READ  = 4'd0,
    OP_WRITE = 4'd1,
    OP_SWAP  = 4'd2,
    OP_ADD   = 4'd3,
    OP_XOR   = 4'd4,
    OP_OR    = 4'd5,
    OP_AND   = 4'd6,
    OP_MIN   = 4'd7,
    OP_MAX   = 4'd8,
    OP_MINU  = 4'd9,
    OP_MAXU  = 4'd10,
    OP_CAS   = 4'd11
  } pu_amo_op_t;

  localparam logic [3:0] OP_RSV_LO = 4'd12;

  function automatic logic op_reserved(input logic [3:0] op);
    return op >= OP_RSV_LO;
  endfunction

  // Reserved opcodes behave as READ, so only real RMW/WRITE ops touch the RAM
  function automatic logic op_writes(input logic [3:0] op);
    return op != OP_READ && !op_reserved(op);
  endfunction

  function automatic int bank_of(input int addr, input int bank_nbits);
    return addr & ((1 << bank_nbits) - 1);
  endfunction

  function automatic int bank_addr_nbits(input int depth_nbits, input int bank_nbits);
    return depth_nbits - bank_nbits;
  endfunction

  function automatic int idx_nbits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pu_amo_bank.sv
// pu_amo_bank: one memory bank with arbiter, 3-stage RMW pipeline, address hazard guard and ALU
module pu_amo_bank import pu_shared_atomic_mem_pkg::*; #(
  parameter int N  = 20,
  parameter int W  = 32,
  parameter int AW = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0][AW-1:0] addr,
  input  logic [N-1:0][3:0]    op,
  input  logic [N-1:0][W-1:0]  wdata,
  input  logic [N-1:0][W-1:0]  cmp,
  output logic [N-1:0]         gnt,
  output logic                 ack,
  output logic [IW-1:0]        ack_idx,
  output logic [W-1:0]         ack_data,
  output logic                 ack_err
);

  logic [N-1:0]  elig;
  logic          g_vld;
  logic [IW-1:0] g_idx;
  logic [W-1:0]  rdata, new_val;
  logic          we;

  logic          s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [IW-1:0] s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d;
  logic [3:0]    s1_op_q, s1_op_d, s2_op_q, s2_op_d;
  logic [AW-1:0] s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
  logic [W-1:0]  s1_wdata_q, s1_wdata_d, s2_wdata_q, s2_wdata_d;
  logic [W-1:0]  s1_cmp_q, s1_cmp_d, s2_cmp_q, s2_cmp_d;
  logic [W-1:0]  s2_old_q, s2_old_d;
  logic          ack_q, ack_d, ack_err_q, ack_err_d;
  logic [IW-1:0] ack_idx_q, ack_idx_d;
  logic [W-1:0]  ack_data_q, ack_data_d;

  assign ack      = ack_q;
  assign ack_idx  = ack_idx_q;
  assign ack_data = ack_data_q;
  assign ack_err  = ack_err_q;

  // a port waits while a writing op to its address is still in S1/S2, so its read sees the result
  always_comb begin
    elig = '0;
    for (int p = 0; p < N; p++)
      elig[p] = req[p]
        && !(s1_vld_q && op_writes(s1_op_q) && s1_addr_q == addr[p])
        && !(s2_vld_q && op_writes(s2_op_q) && s2_addr_q == addr[p]);
  end

  rr_arb #(.N(N), .IW(IW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (elig),
    .gnt_vld (g_vld),
    .gnt_idx (g_idx)
  );

  ram_1r1w #(.W(W), .AW(AW)) u_ram (
    .clk   (clk),
    .re    (g_vld),
    .raddr (addr[g_idx]),
    .we    (we),
    .waddr (s2_addr_q),
    .wdata (new_val),
    .rdata (rdata)
  );

  // S0 grant decode and S0->S1->S2 stage advance
  always_comb begin
    gnt = '0;
    for (int p = 0; p < N; p++) gnt[p] = g_vld && g_idx == IW'(p);
    s1_vld_d   = g_vld;
    s1_idx_d   = g_idx;
    s1_op_d    = op[g_idx];
    s1_addr_d  = addr[g_idx];
    s1_wdata_d = wdata[g_idx];
    s1_cmp_d   = cmp[g_idx];
    s2_vld_d   = s1_vld_q;
    s2_idx_d   = s1_idx_q;
    s2_op_d    = s1_op_q;
    s2_addr_d  = s1_addr_q;
    s2_wdata_d = s1_wdata_q;
    s2_cmp_d   = s1_cmp_q;
    s2_old_d   = rdata;
  end

  // S2 ALU, write-back and ack; reset suppresses the write so RAM keeps the whole old word
  always_comb begin
    case (s2_op_q)
      OP_WRITE, OP_SWAP: new_val = s2_wdata_q;
      OP_ADD:  new_val = s2_old_q + s2_wdata_q;
      OP_XOR:  new_val = s2_old_q ^ s2_wdata_q;
      OP_OR:   new_val = s2_old_q | s2_wdata_q;
      OP_AND:  new_val = s2_old_q & s2_wdata_q;
      OP_MIN:  new_val = $signed(s2_wdata_q) < $signed(s2_old_q) ? s2_wdata_q : s2_old_q;
      OP_MAX:  new_val = $signed(s2_wdata_q) > $signed(s2_old_q) ? s2_wdata_q : s2_old_q;
      OP_MINU: new_val = s2_wdata_q < s2_old_q ? s2_wdata_q : s2_old_q;
      OP_MAXU: new_val = s2_wdata_q > s2_old_q ? s2_wdata_q : s2_old_q;
      OP_CAS:  new_val = s2_old_q == s2_cmp_q ? s2_wdata_q : s2_old_q;
      default: new_val = s2_old_q;
    endcase
    we         = s2_vld_q && op_writes(s2_op_q) && !rst;
    ack_d      = s2_vld_q;
    ack_idx_d  = s2_idx_q;
    ack_data_d = s2_vld_q ? s2_old_q : '0;
    ack_err_d  = s2_vld_q && op_reserved(s2_op_q);
  end

  // pipeline registers; only valids and ack outputs need reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      ack_q      <= 1'b0;
      ack_data_q <= '0;
      ack_err_q  <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      ack_q      <= ack_d;
      ack_data_q <= ack_data_d;
      ack_err_q  <= ack_err_d;
    end
    s1_idx_q   <= s1_idx_d;
    s1_op_q    <= s1_op_d;
    s1_addr_q  <= s1_addr_d;
    s1_wdata_q <= s1_wdata_d;
    s1_cmp_q   <= s1_cmp_d;
    s2_idx_q   <= s2_idx_d;
    s2_op_q    <= s2_op_d;
    s2_addr_q  <= s2_addr_d;
    s2_wdata_q <= s2_wdata_d;
    s2_cmp_q   <= s2_cmp_d;
    s2_old_q   <= s2_old_d;
    ack_idx_q  <= ack_idx_d;
  end

endmodule

// File: rtl/ram_1r1w.sv
// ram_1r1w: one read / one write port RAM with registered read; same-cycle collision returns old data
module ram_1r1w #(
  parameter int W  = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [1 << AW];
  logic [W-1:0] rdata_q;

  assign rdata = rdata_q;

  // storage and registered read, contents deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

endmodule

// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter; the pointer moves past the winner only when a grant is made
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  hi;

  // lowest requester at or above the pointer, else lowest requester overall
  always_comb begin
    hi = '0;
    for (int i = 0; i < N; i++) hi[i] = req[i] && i >= int'(ptr_q);
    gnt_vld = |req;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) gnt_idx = IW'(i);
    for (int i = N - 1; i >= 0; i--) if (hi[i]) gnt_idx = IW'(i);
    ptr_d = !gnt_vld ? ptr_q : gnt_idx == IW'(N - 1) ? '0 : gnt_idx + 1'b1;
  end

  // pointer register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pu_shared_atomic_mem.sv
// pu_shared_atomic_mem: multi-port, address-interleaved atomic scratch memory
module pu_shared_atomic_mem import pu_shared_atomic_mem_pkg::*; #(
  parameter int NUM_OF_PU   = 20,
  parameter int WIDTH_NBITS = 32,
  parameter int DEPTH_NBITS = 10,
  parameter int BANK_NBITS  = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_OF_PU-1:0]                   io_req,
  input  logic [NUM_OF_PU-1:0][3:0]              io_op,
  input  logic [NUM_OF_PU-1:0][DEPTH_NBITS-1:0]  io_addr,
  input  logic [NUM_OF_PU-1:0][WIDTH_NBITS-1:0]  io_wdata,
  input  logic [NUM_OF_PU-1:0][WIDTH_NBITS-1:0]  io_cmp,
  output logic [NUM_OF_PU-1:0]                   io_ack,
  output logic [NUM_OF_PU-1:0][WIDTH_NBITS-1:0]  io_ack_data,
  output logic [NUM_OF_PU-1:0]                   io_ack_err
);

  localparam int NB = 1 << BANK_NBITS;
  localparam int LW = bank_addr_nbits(DEPTH_NBITS, BANK_NBITS);
  localparam int IW = idx_nbits(NUM_OF_PU);

  logic [NUM_OF_PU-1:0]                  busy_q, busy_d, gnt;
  logic [NUM_OF_PU-1:0][3:0]             op_q, op_d;
  logic [NUM_OF_PU-1:0][DEPTH_NBITS-1:0] addr_q, addr_d;
  logic [NUM_OF_PU-1:0][WIDTH_NBITS-1:0] wdata_q, wdata_d, cmp_q, cmp_d;
  logic [NUM_OF_PU-1:0][LW-1:0]          laddr;
  logic [NB-1:0][NUM_OF_PU-1:0]          breq, bgnt;
  logic [NB-1:0]                         back, berr;
  logic [NB-1:0][IW-1:0]                 bidx;
  logic [NB-1:0][WIDTH_NBITS-1:0]        bdata;

  // holding registers: accept a request only when idle, release on grant
  always_comb begin
    busy_d  = busy_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cmp_d   = cmp_q;
    for (int p = 0; p < NUM_OF_PU; p++) begin
      if (busy_q[p]) busy_d[p] = !gnt[p];
      else if (io_req[p]) begin
        busy_d[p]  = 1'b1;
        op_d[p]    = io_op[p];
        addr_d[p]  = io_addr[p];
        wdata_d[p] = io_wdata[p];
        cmp_d[p]   = io_cmp[p];
      end
    end
  end

  // holding register state
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    cmp_q   <= cmp_d;
  end

  // route pending requests to their bank by the low address bits
  always_comb begin
    breq  = '0;
    laddr = '0;
    gnt   = '0;
    for (int p = 0; p < NUM_OF_PU; p++) begin
      laddr[p] = LW'(addr_q[p] >> BANK_NBITS);
      for (int b = 0; b < NB; b++)
        breq[b][p] = busy_q[p] && bank_of(int'(addr_q[p]), BANK_NBITS) == b;
    end
    for (int b = 0; b < NB; b++) gnt = gnt | bgnt[b];
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    pu_amo_bank #(.N(NUM_OF_PU), .W(WIDTH_NBITS), .AW(LW), .IW(IW)) u_bank (
      .clk      (clk),
      .rst      (rst),
      .req      (breq[b]),
      .addr     (laddr),
      .op       (op_q),
      .wdata    (wdata_q),
      .cmp      (cmp_q),
      .gnt      (bgnt[b]),
      .ack      (back[b]),
      .ack_idx  (bidx[b]),
      .ack_data (bdata[b]),
      .ack_err  (berr[b])
    );
  end

  // ack mux: a port has at most one op in flight, so at most one bank acks it
  always_comb begin
    io_ack      = '0;
    io_ack_data = '0;
    io_ack_err  = '0;
    for (int b = 0; b < NB; b++)
      for (int p = 0; p < NUM_OF_PU; p++)
        if (back[b] && int'(bidx[b]) == p) begin
          io_ack[p]      = 1'b1;
          io_ack_data[p] = bdata[b];
          io_ack_err[p]  = berr[b];
        end
  end

endmodule

// File: tb/tb_pu_shared_atomic_mem.sv
// tb_pu_shared_atomic_mem: table-driven and scoreboarded checks of the banked atomic memory
module tb_pu_shared_atomic_mem;
  import pu_shared_atomic_mem_pkg::*;

  localparam int N = 20, W = 32, D = 10;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]        io_req, io_ack, io_ack_err;
  logic [N-1:0][3:0]   io_op;
  logic [N-1:0][D-1:0] io_addr;
  logic [N-1:0][W-1:0] io_wdata, io_cmp, io_ack_data;

  pu_shared_atomic_mem #(.NUM_OF_PU(N), .WIDTH_NBITS(W), .DEPTH_NBITS(D), .BANK_NBITS(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_req      (io_req),
    .io_op       (io_op),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .io_cmp      (io_cmp),
    .io_ack      (io_ack),
    .io_ack_data (io_ack_data),
    .io_ack_err  (io_ack_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0, idle_bad = 0;

  typedef struct {
    int         port;
    logic [W-1:0] data;
    logic [W-1:0] alt;
    logic       err;
    int         due;
    bit         any;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int         port;
    logic [3:0] op;
    int         addr;
    logic [W-1:0] wd;
    logic [W-1:0] cm;
    logic [W-1:0] exp;
    logic       err;
  } vec_t;
  vec_t tbl[26];

  bit collect = 0;
  int col_n = 0, col_last = 0, col_gapbad = 0;
  logic [W-1:0] col_val[$];

  // monitor: match every ack against the scoreboard, or collect for the contention test
  always @(negedge clk) begin
    if (!rst) for (int p = 0; p < N; p++) begin
      if (!io_ack[p] && (io_ack_data[p] !== '0 || io_ack_err[p] !== 1'b0)) idle_bad++;
      if (io_ack[p]) begin
        if (collect) begin
          col_val.push_back(io_ack_data[p]);
          if (col_n > 0 && cyc - col_last < 3) col_gapbad++;
          col_last = cyc;
          col_n++;
        end else begin
          int k;
          k = -1;
          foreach (sb[i]) if (k < 0 && sb[i].port == p) k = i;
          tests++;
          if (k < 0) begin
            fails++;
            $display("FAIL unexpected_ack port %0d: got data %h err %0b at cyc %0d, required no ack",
                     p, io_ack_data[p], io_ack_err[p], cyc);
          end else begin
            if ((!sb[k].any && io_ack_data[p] !== sb[k].data && io_ack_data[p] !== sb[k].alt)
                || io_ack_err[p] !== sb[k].err || (sb[k].due >= 0 && cyc != sb[k].due)) begin
              fails++;
              $display("FAIL ack port %0d: got data %h err %0b cyc %0d, required data %h err %0b cyc %0d",
                       p, io_ack_data[p], io_ack_err[p], cyc, sb[k].data, sb[k].err, sb[k].due);
            end
            sb.delete(k);
          end
        end
      end
    end
  end

  task automatic drive(input int p, input logic [3:0] op, input int a, input logic [W-1:0] wd,
                       input logic [W-1:0] cm);
    io_req[p]   = 1'b1;
    io_op[p]    = op;
    io_addr[p]  = D'(a);
    io_wdata[p] = wd;
    io_cmp[p]   = cm;
  endtask

  task automatic push(input int p, input logic [W-1:0] d, input logic [W-1:0] alt, input logic e,
                      input int due, input bit any);
    exp_t x;
    x.port = p; x.data = d; x.alt = alt; x.err = e; x.due = due; x.any = any;
    sb.push_back(x);
  endtask

  task automatic step;
    @(negedge clk);
    io_req = '0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d acks outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    bit [N-1:0] seen;
    int badv;
    rst = 1'b1;
    io_req = '0; io_op = '0; io_addr = '0; io_wdata = '0; io_cmp = '0;
    tbl[0]  = '{0,  OP_WRITE, 5, 32'h1234,     32'h0, 32'h0,        1'b0};
    tbl[1]  = '{3,  OP_READ,  5, 32'h0,        32'h0, 32'h1234,     1'b0};
    tbl[2]  = '{1,  OP_WRITE, 2, 32'h7,        32'h0, 32'h0,        1'b0};
    tbl[3]  = '{2,  OP_CAS,   2, 32'h9,        32'h7, 32'h7,        1'b0};
    tbl[4]  = '{4,  OP_CAS,   2, 32'h1,        32'h7, 32'h9,        1'b0};
    tbl[5]  = '{5,  OP_READ,  2, 32'h0,        32'h0, 32'h9,        1'b0};
    tbl[6]  = '{6,  OP_WRITE, 4, 32'hFFFFFFFF, 32'h0, 32'h0,        1'b0};
    tbl[7]  = '{7,  OP_MIN,   4, 32'h1,        32'h0, 32'hFFFFFFFF, 1'b0};
    tbl[8]  = '{8,  OP_MINU,  4, 32'h1,        32'h0, 32'hFFFFFFFF, 1'b0};
    tbl[9]  = '{9,  OP_READ,  4, 32'h0,        32'h0, 32'h1,        1'b0};
    tbl[10] = '{10, OP_MAX,   4, 32'hFFFFFFFB, 32'h0, 32'h1,        1'b0};
    tbl[11] = '{11, OP_MAXU,  4, 32'hFFFFFFFB, 32'h0, 32'h1,        1'b0};
    tbl[12] = '{12, OP_SWAP,  4, 32'h3,        32'h0, 32'hFFFFFFFB, 1'b0};
    tbl[13] = '{13, OP_ADD,   4, 32'hFFFFFFFF, 32'h0, 32'h3,        1'b0};
    tbl[14] = '{14, OP_XOR,   4, 32'h6,        32'h0, 32'h2,        1'b0};
    tbl[15] = '{15, OP_OR,    4, 32'h1,        32'h0, 32'h4,        1'b0};
    tbl[16] = '{16, OP_AND,   4, 32'h6,        32'h0, 32'h5,        1'b0};
    tbl[17] = '{17, 4'd13,    4, 32'h99,       32'h0, 32'h4,        1'b1};
    tbl[18] = '{18, OP_READ,  4, 32'h0,        32'h0, 32'h4,        1'b0};
    tbl[19] = '{19, OP_MIN,   4, 32'h3,        32'h0, 32'h4,        1'b0};
    tbl[20] = '{0,  OP_MAXU,  4, 32'h2,        32'h0, 32'h3,        1'b0};
    tbl[21] = '{1,  OP_READ,  4, 32'h0,        32'h0, 32'h3,        1'b0};
    tbl[22] = '{3,  4'd15,    7, 32'h5,        32'h0, 32'h0,        1'b1};
    tbl[23] = '{2,  OP_READ,  7, 32'h0,        32'h0, 32'h0,        1'b0};
    tbl[24] = '{9,  OP_MAX,   4, 32'h7,        32'h0, 32'h3,        1'b0};
    tbl[25] = '{10, OP_READ,  4, 32'h0,        32'h0, 32'h7,        1'b0};

    repeat (3) @(negedge clk);
    tests++;
    if (io_ack !== '0 || io_ack_data !== '0 || io_ack_err !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ack %h err %h, required all 0", io_ack, io_ack_err);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int a = 0; a < 16; a++) begin
      drive(a, OP_WRITE, a, '0, '0);
      push(a, '0, '0, 1'b0, -1, 1'b1);
    end
    step();
    wait_idle(60);

    foreach (tbl[i]) begin
      drive(tbl[i].port, tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].cm);
      push(tbl[i].port, tbl[i].exp, tbl[i].exp, tbl[i].err, cyc + 4, 1'b0);
      step();
      wait_idle(20);
    end

    for (int i = 0; i < 4; i++) begin
      drive(i, OP_READ, 12 + i, '0, '0);
      push(i, '0, '0, 1'b0, cyc + 4, 1'b0);
    end
    step();
    wait_idle(20);

    collect = 1;
    col_n = 0; col_gapbad = 0; col_val.delete();
    for (int p = 0; p < N; p++) drive(p, OP_ADD, 8, 32'h1, '0);
    step();
    drive(0, OP_READ, 8, '0, '0);
    step();
    for (int i = 0; i < 300 && col_n < N; i++) @(negedge clk);
    repeat (8) @(negedge clk);
    collect = 0;
    tests++;
    if (col_n != N) begin
      fails++;
      $display("FAIL add_ack_count: got %0d acks, required %0d", col_n, N);
    end
    seen = '0;
    badv = 0;
    foreach (col_val[i]) if (col_val[i] < N && !seen[col_val[i]]) seen[col_val[i]] = 1'b1; else badv++;
    tests++;
    if (seen != {N{1'b1}} || badv != 0) begin
      fails++;
      $display("FAIL add_old_values: got seen %h with %0d bad, required every value 0..%0d once", seen, badv, N - 1);
    end
    tests++;
    if (col_gapbad != 0) begin
      fails++;
      $display("FAIL add_spacing: got %0d same-address acks under 3 cycles apart, required 0", col_gapbad);
    end
    drive(7, OP_READ, 8, '0, '0);
    push(7, N, N, 1'b0, cyc + 4, 1'b0);
    step();
    wait_idle(20);

    drive(5, OP_ADD, 9, 32'h5, '0);
    step();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (io_ack !== '0 || io_ack_data !== '0 || io_ack_err !== '0) begin
      fails++;
      $display("FAIL reset_midop: got ack %h err %h, required all 0", io_ack, io_ack_err);
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    drive(6, OP_READ, 9, '0, '0);
    push(6, '0, 32'h5, 1'b0, cyc + 4, 1'b0);
    step();
    wait_idle(20);

    tests++;
    if (idle_bad != 0) begin
      fails++;
      $display("FAIL idle_outputs: got %0d non-zero data/err on non-acked ports, required 0", idle_bad);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
